sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, successor to the fixed 4-bit sync FIFO.
Adds configurable width, depth and thresholds, an occupancy count, almost-full/almost-empty flags, overflow/underflow pulses, and a selectable first-word-fall-through (FWFT) read mode.
Sits between producer and consumer logic in the same clock domain and is the standard buffer for new datapath blocks.

---
 rtl/sync_fifo_param_if.sv | 30 +++
 rtl/sync_fifo_param.sv | 98 +++++++++
 tb/tb_sync_fifo_param.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param.
// master = the logic that writes and pops the FIFO, slave = the FIFO itself.
interface sync_fifo_param_if #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              wr_en;
  logic [DWIDTH-1:0] din;
  logic              rd_en;
  logic [DWIDTH-1:0] dout;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// overflow/underflow pulses and optional first-word-fall-through read.
module sync_fifo_param #(
  parameter int DWIDTH    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_param_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

  if (DEPTH < 2) begin : g_chk_depth
    $error("sync_fifo_param: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
    $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_chk_ae
    $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, unf_q;
  logic              empty, full, rd_acc, wr_acc;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_FULL);
    rd_acc   = bus.rd_en && !empty;
    // A write while full only goes in when the same-cycle pop frees a slot.
    wr_acc   = bus.wr_en && (!full || bus.rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Explicit wrap so non-power-of-2 depths index correctly.
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= bus.wr_en && full && !bus.rd_en;
      unf_q    <= bus.rd_en && empty;
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.din;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.dout = empty ? '0 : mem[rd_ptr_q];
  end else begin : g_reg
    logic [DWIDTH-1:0] dout_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)        dout_q <= '0;
      else if (rd_acc) dout_q <= mem[rd_ptr_q];
    end
    assign bus.dout = dout_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  a_full_empty: assert property (@(posedge clk) disable iff (!rst) !(full && empty));
  a_count_max:  assert property (@(posedge clk) disable iff (!rst) count_q <= CNT_FULL);
  a_post_rst:   assert property (@(posedge clk) $rose(rst) |-> (empty && !full));
  a_overflow:   assert property (@(posedge clk) disable iff (!rst)
                  (full && bus.wr_en && !bus.rd_en) |=> ($stable(full) && ovf_q));
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: standard 16-deep, FWFT 16-deep and 5-deep instances.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  sync_fifo_param_if #(.DWIDTH(8), .DEPTH(16)) ba ();
  sync_fifo_param_if #(.DWIDTH(8), .DEPTH(16)) bb ();
  sync_fifo_param_if #(.DWIDTH(8), .DEPTH(5))  bc ();

  sync_fifo_param #(.DWIDTH(8), .DEPTH(16), .FWFT(0)) u_a (.clk(clk), .rst(rst), .bus(ba));
  sync_fifo_param #(.DWIDTH(8), .DEPTH(16), .FWFT(1)) u_b (.clk(clk), .rst(rst), .bus(bb));
  sync_fifo_param #(.DWIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0))
    u_c (.clk(clk), .rst(rst), .bus(bc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [7:0] q [$];
  logic [7:0] exp_d;
  logic       wr, rd, ra, wa;
  int         sz, nw;

  initial begin
    rst = 1'b0;
    ba.wr_en = 0; ba.rd_en = 0; ba.din = '0;
    bb.wr_en = 0; bb.rd_en = 0; bb.din = '0;
    bc.wr_en = 0; bc.rd_en = 0; bc.din = '0;
    repeat (2) tick();
    rst = 1'b1;

    // ---- 1: asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      ba.wr_en = 1; ba.din = 8'(8'h11 * (i + 1)); tick();
    end
    ba.wr_en = 0; ba.rd_en = 1; tick(); ba.rd_en = 0;
    chk("pre_rst_dout",  32'(ba.dout),  32'h11);
    chk("pre_rst_count", 32'(ba.count), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("rst_count", 32'(ba.count),        32'd0);
    chk("rst_empty", 32'(ba.empty),        32'd1);
    chk("rst_ae",    32'(ba.almost_empty), 32'd1);
    chk("rst_full",  32'(ba.full),         32'd0);
    chk("rst_af",    32'(ba.almost_full),  32'd0);
    chk("rst_ovf",   32'(ba.overflow),     32'd0);
    chk("rst_unf",   32'(ba.underflow),    32'd0);
    chk("rst_dout",  32'(ba.dout),         32'd0);
    chk("rst_c_empty", 32'(bc.empty),      32'd1);
    rst = 1'b1;

    // ---- 2: fill and drain in order
    for (int i = 0; i < 16; i++) begin
      ba.wr_en = 1; ba.din = 8'(i); tick();
      chk("fill_count", 32'(ba.count),       32'(i + 1));
      chk("fill_af",    32'(ba.almost_full), 32'(i + 1 >= 14));
      chk("fill_ae",    32'(ba.almost_empty), 32'(i + 1 <= 2));
      chk("fill_full",  32'(ba.full),        32'(i == 15));
    end
    ba.wr_en = 0;
    for (int i = 0; i < 16; i++) begin
      ba.rd_en = 1; tick();
      chk("drain_dout",  32'(ba.dout),  32'(i));
      chk("drain_count", 32'(ba.count), 32'(15 - i));
    end
    ba.rd_en = 0;
    chk("drain_empty", 32'(ba.empty), 32'd1);

    // ---- 3: overflow and underflow
    for (int i = 0; i < 16; i++) begin
      ba.wr_en = 1; ba.din = 8'(8'h80 + i); tick();
    end
    chk("ovf_pre_full", 32'(ba.full), 32'd1);
    ba.wr_en = 1; ba.din = 8'hAA; tick(); ba.wr_en = 0;
    chk("ovf_pulse", 32'(ba.overflow), 32'd1);
    chk("ovf_count", 32'(ba.count),    32'd16);
    chk("ovf_full",  32'(ba.full),     32'd1);
    tick();
    chk("ovf_clear", 32'(ba.overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      ba.rd_en = 1; tick();
      chk("ovf_drain", 32'(ba.dout), 32'(8'h80 + i));
    end
    ba.rd_en = 1; tick(); ba.rd_en = 0;
    chk("unf_pulse", 32'(ba.underflow), 32'd1);
    chk("unf_dout",  32'(ba.dout),      32'h8F);
    chk("unf_count", 32'(ba.count),     32'd0);
    tick();
    chk("unf_clear", 32'(ba.underflow), 32'd0);
    ba.rd_en = 1; ba.wr_en = 1; ba.din = 8'h77; tick();
    chk("unf_wr_pulse", 32'(ba.underflow), 32'd1);
    chk("unf_wr_dout",  32'(ba.dout),      32'h8F);
    chk("unf_wr_count", 32'(ba.count),     32'd1);
    ba.wr_en = 0; tick(); ba.rd_en = 0;
    chk("unf_wr_read",  32'(ba.dout),      32'h77);
    chk("unf_wr_empty", 32'(ba.empty),     32'd1);

    // ---- 4: simultaneous read/write at count=1 and at full
    ba.wr_en = 1; ba.din = 8'h01; tick();
    ba.rd_en = 1; ba.din = 8'h02; tick();
    chk("rw1_count", 32'(ba.count),     32'd1);
    chk("rw1_dout",  32'(ba.dout),      32'h01);
    chk("rw1_ovf",   32'(ba.overflow),  32'd0);
    chk("rw1_unf",   32'(ba.underflow), 32'd0);
    ba.wr_en = 0; tick(); ba.rd_en = 0;
    chk("rw1_next", 32'(ba.dout), 32'h02);
    for (int i = 0; i < 16; i++) begin
      ba.wr_en = 1; ba.din = 8'(8'h40 + i); tick();
    end
    ba.rd_en = 1; ba.din = 8'h50; tick(); ba.wr_en = 0;
    chk("rwf_count", 32'(ba.count),    32'd16);
    chk("rwf_full",  32'(ba.full),     32'd1);
    chk("rwf_dout",  32'(ba.dout),     32'h40);
    chk("rwf_ovf",   32'(ba.overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("rwf_drain", 32'(ba.dout), (i < 15) ? 32'(8'h41 + i) : 32'h50);
    end
    ba.rd_en = 0;

    // 40 random words with random pops, checked against a queue
    q.delete(); nw = 0; exp_d = 8'h50;
    for (int s = 0; s < 90; s++) begin
      wr = (nw < 40) && ($urandom_range(3) != 0);
      rd = ($urandom_range(1) == 1);
      sz = q.size();
      ra = rd && (sz != 0);
      wa = wr && ((sz != 16) || rd);
      ba.wr_en = wr; ba.rd_en = rd; ba.din = 8'($urandom);
      if (ra) exp_d = q.pop_front();
      if (wa) begin q.push_back(ba.din); nw++; end
      tick();
      chk("rnd_dout",  32'(ba.dout),      32'(exp_d));
      chk("rnd_count", 32'(ba.count),     32'(q.size()));
      chk("rnd_ovf",   32'(ba.overflow),  32'(wr && !rd && sz == 16));
      chk("rnd_unf",   32'(ba.underflow), 32'(rd && sz == 0));
    end
    ba.wr_en = 0;
    for (int s = 0; s < 20 && q.size() != 0; s++) begin
      ba.rd_en = 1; exp_d = q.pop_front(); tick();
      chk("rnd_tail", 32'(ba.dout), 32'(exp_d));
    end
    ba.rd_en = 0;
    chk("rnd_empty", 32'(ba.empty), 32'd1);

    // ---- 5: FWFT instance
    bb.wr_en = 1; bb.din = 8'h5A; tick(); bb.wr_en = 0;
    chk("fwft_empty", 32'(bb.empty), 32'd0);
    chk("fwft_dout",  32'(bb.dout),  32'h5A);
    tick();
    chk("fwft_hold",  32'(bb.dout),  32'h5A);
    bb.rd_en = 1; tick(); bb.rd_en = 0;
    chk("fwft_pop_empty", 32'(bb.empty), 32'd1);
    for (int i = 0; i < 16; i++) begin
      bb.wr_en = 1; bb.din = 8'(i); tick();
      chk("fwft_fill_count", 32'(bb.count),       32'(i + 1));
      chk("fwft_fill_af",    32'(bb.almost_full), 32'(i + 1 >= 14));
      chk("fwft_head",       32'(bb.dout),        32'd0);
    end
    bb.wr_en = 0;
    chk("fwft_full", 32'(bb.full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("fwft_drain", 32'(bb.dout), 32'(i));
      bb.rd_en = 1; tick();
    end
    bb.rd_en = 0;
    chk("fwft_drain_empty", 32'(bb.empty), 32'd1);

    // ---- 6: DEPTH=5, AF=4, AE=1 with wrap
    q.delete(); nw = 0; exp_d = 8'h00;
    for (int s = 0; s < 40; s++) begin
      wr = (nw < 12) && (s % 4 != 3);
      rd = (s % 4 == 3) || ((s % 4 == 1) && (s >= 4)) || (nw >= 12);
      sz = q.size();
      ra = rd && (sz != 0);
      wa = wr && ((sz != 5) || rd);
      bc.wr_en = wr; bc.rd_en = rd; bc.din = 8'(8'hC0 + nw);
      if (ra) exp_d = q.pop_front();
      if (wa) begin q.push_back(bc.din); nw++; end
      tick();
      chk("d5_dout",  32'(bc.dout),         32'(exp_d));
      chk("d5_count", 32'(bc.count),        32'(q.size()));
      chk("d5_af",    32'(bc.almost_full),  32'(q.size() >= 4));
      chk("d5_ae",    32'(bc.almost_empty), 32'(q.size() <= 1));
      chk("d5_full",  32'(bc.full),         32'(q.size() == 5));
      chk("d5_ovf",   32'(bc.overflow),     32'(wr && !rd && sz == 5));
    end
    bc.wr_en = 0; bc.rd_en = 0;
    chk("d5_all_written", 32'(nw), 32'd12);
    chk("d5_empty", 32'(bc.empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
